fb_double_buffer: RTL
=====================

Name: fb_double_buffer

Overview:
- Double-buffered frame store directly downstream of the z-buffer stage.
- Accepts depth-resolved pixel writes (valid, 12-bit address, 10-bit colour) into a back buffer.
- Serves the display scan-out from a front buffer.
- Swaps buffers on a frame boundary, then hardware-clears the new back buffer before the next frame is drawn; emits a one-cycle pulse to reset the z-buffer for the new frame.

Parameters:
- SIZE, 4096, pixels per buffer (64x64).
- PIX_W, 10, colour bits per pixel.
- BG_COLOR, 10'h000, value written during clear.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  pixel write strobe (from z-buffer valid_out).
- wr_addr  in  12  pixel address (from z-buffer pixel_addr).
- wr_pixel  in  PIX_W  pixel colour (from z-buffer pixel_out).
- wr_ready  out  1  high when writes are accepted (DRAW state only).
- frame_done  in  1  one-cycle pulse: renderer finished the back frame.
- rd_frame_start  in  1  one-cycle pulse from display timing (vsync).
- rd_addr  in  12  display read address.
- rd_pixel  out  PIX_W  front-buffer data.
- rd_valid  out  1  rd_pixel valid; tracks rd_en 2 cycles later.
- rd_en  in  1  display read request.
- zb_clear  out  1  one-cycle pulse to reset the z-buffer.
- front_sel  out  1  bank currently displayed.
- drop_cnt  out  16  writes dropped while wr_ready low; saturates at 16'hFFFF.

Behaviour:
Reset (async, any time, including mid-clear):
- state=DRAW, front_sel=0 (back = bank 1).
- wr_ready=1, rd_valid=0, rd_pixel=0, zb_clear=0, drop_cnt=0.
- Memory contents are not cleared by reset.

States:
- DRAW: wr_ready=1. A write with wr_valid=1 stores wr_pixel at back[wr_addr]; visible to reads one cycle later once that bank is front. frame_done -> SWAP_WAIT. A write in the same cycle as frame_done is still committed.
- SWAP_WAIT: wr_ready=0; writes dropped and counted in drop_cnt. On rd_frame_start: front_sel toggles, zb_clear=1 for that single cycle, clear counter=0, -> CLEAR.
- CLEAR: wr_ready=0. Each cycle writes BG_COLOR to back[clr_cnt] and increments clr_cnt. After address SIZE-1 is written -> DRAW, taking exactly SIZE cycles. Writes arriving during CLEAR are dropped and counted.
- frame_done outside DRAW is ignored.
- rd_frame_start in DRAW or CLEAR has no effect.

Read path:
- rd_addr/rd_en are registered, the BRAM read is registered, then output: 2-cycle latency.
- Bank selection uses the front_sel value in the cycle rd_en is sampled. If rd_frame_start causes a swap in that cycle, the pre-swap front_sel is used; the new bank applies from the next cycle.
- rd_valid = rd_en delayed by 2 cycles.
- rd_pixel holds its last value when rd_valid=0.
- Reads never see the back buffer; writes and clear never touch the front buffer.

Width and boundary rules:
- wr_addr/rd_addr >= SIZE (only possible if SIZE<4096): write ignored and not counted; read returns BG_COLOR.
- drop_cnt saturates; it is not cleared by swap.

Decomposition:
- Package fb_pkg: ADDR_W=12, default SIZE/PIX_W, and the state enum typedef (DRAW, SWAP_WAIT, CLEAR).
- Sub-module fb_bram: simple dual-port RAM (1 write port, 1 registered read port), depth SIZE, width PIX_W.
- Instantiate fb_bram twice as bank 0 and bank 1.
- Write-port mux (clear vs pixel) and read-data mux stay in the top module.

Test Plan:
1. Reset, then write addr 12'h001 = 10'h2A5 in DRAW. frame_done, then rd_frame_start. -> zb_clear pulses 1 cycle, front_sel=1. Read addr 1 with rd_en, then 2 cycles later -> rd_valid=1, rd_pixel=10'h2A5.
2. After swap, count cycles from zb_clear to wr_ready=1 -> exactly 4096 cycles. Then swap again and read any address of the cleared bank -> BG_COLOR.
3. Three wr_valid pulses during SWAP_WAIT and two during CLEAR -> drop_cnt=5; front buffer data unchanged.
4. wr_valid and frame_done in the same cycle (addr 12'h040 = 10'h155) -> write committed; after swap, read addr 12'h040 -> 10'h155.
5. rd_en issued in the same cycle as the swapping rd_frame_start -> data from the old front bank. A read one cycle later -> data from the new bank.
6. Assert rst for 1 cycle mid-CLEAR (clr_cnt ~ 2000) -> immediately: state DRAW, wr_ready=1, front_sel=0, drop_cnt=0, rd_valid=0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and state type for the double-buffered frame store.
package fb_pkg;
    localparam int ADDR_W    = 12;
    localparam int SIZE_DEF  = 4096;
    localparam int PIX_W_DEF = 10;

    typedef enum logic [1:0] {
        DRAW      = 2'd0,
        SWAP_WAIT = 2'd1,
        CLEAR     = 2'd2
    } fb_state_t;
endpackage

// File: rtl/fb_bram.sv
// Simple dual-port RAM: one write port, one registered read port.
module fb_bram
    import fb_pkg::*;
#(
    parameter int SIZE  = SIZE_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [PIX_W-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [PIX_W-1:0]  rdata
);
    logic [PIX_W-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fb_double_buffer.sv
// Double-buffered frame store: pixel writes go to the back bank, scan-out reads
// the front bank; banks swap on vsync after frame_done and the new back is cleared.
module fb_double_buffer
    import fb_pkg::*;
#(
    parameter int               SIZE     = SIZE_DEF,
    parameter int               PIX_W    = PIX_W_DEF,
    parameter logic [PIX_W-1:0] BG_COLOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_pixel,
    output logic              wr_ready,
    input  logic              frame_done,
    input  logic              rd_frame_start,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_pixel,
    output logic              rd_valid,
    input  logic              rd_en,
    output logic              zb_clear,
    output logic              front_sel,
    output logic [15:0]       drop_cnt
);
    localparam logic [ADDR_W:0]   SIZE_X   = (ADDR_W+1)'(SIZE);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(SIZE - 1);

    fb_state_t         state, state_nxt;
    logic              swap;
    logic [ADDR_W-1:0] clr_cnt;
    logic              wr_in_range, rd_in_range, drop;

    logic              bk_we, we0, we1, re0, re1;
    logic [ADDR_W-1:0] bk_waddr;
    logic [PIX_W-1:0]  bk_wdata, rdata0, rdata1;

    logic              vld_p0, sel_p0, oob_p0;

    assign wr_in_range = {1'b0, wr_addr} < SIZE_X;
    assign rd_in_range = {1'b0, rd_addr} < SIZE_X;
    assign wr_ready    = (state == DRAW);
    assign drop        = wr_valid & ~wr_ready & wr_in_range;

    always_comb begin
        state_nxt = state;
        swap      = 1'b0;
        case (state)
            DRAW:      if (frame_done) state_nxt = SWAP_WAIT;
            SWAP_WAIT: if (rd_frame_start) begin
                           state_nxt = CLEAR;
                           swap      = 1'b1;
                       end
            CLEAR:     if (clr_cnt == CLR_LAST) state_nxt = DRAW;
            default:   state_nxt = DRAW;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DRAW;
            front_sel <= 1'b0;
            zb_clear  <= 1'b0;
            clr_cnt   <= '0;
            drop_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            zb_clear <= swap;
            if (swap) front_sel <= ~front_sel;
            if (swap) clr_cnt <= '0;
            else if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Back-bank write port: the clear sweep owns it for the whole CLEAR state.
    always_comb begin
        bk_we    = 1'b0;
        bk_waddr = wr_addr;
        bk_wdata = wr_pixel;
        if (state == CLEAR) begin
            bk_we    = 1'b1;
            bk_waddr = clr_cnt;
            bk_wdata = BG_COLOR;
        end else if (state == DRAW && wr_valid && wr_in_range) begin
            bk_we = 1'b1;
        end
    end

    assign we0 = bk_we &  front_sel;
    assign we1 = bk_we & ~front_sel;
    assign re0 = rd_en & rd_in_range & ~front_sel;
    assign re1 = rd_en & rd_in_range &  front_sel;

    fb_bram #(.SIZE(SIZE), .PIX_W(PIX_W)) u_bank0 (
        .clk(clk), .we(we0), .waddr(bk_waddr), .wdata(bk_wdata),
        .re(re0), .raddr(rd_addr), .rdata(rdata0)
    );

    fb_bram #(.SIZE(SIZE), .PIX_W(PIX_W)) u_bank1 (
        .clk(clk), .we(we1), .waddr(bk_waddr), .wdata(bk_wdata),
        .re(re1), .raddr(rd_addr), .rdata(rdata1)
    );

    // Stage p0: BRAM read in flight; bank choice frozen at the sampling edge.
    always_ff @(posedge clk) begin
        sel_p0 <= front_sel;
        oob_p0 <= ~rd_in_range;
    end

    // Output stage: rd_pixel holds between valid reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            rd_valid <= 1'b0;
            rd_pixel <= '0;
        end else begin
            vld_p0   <= rd_en;
            rd_valid <= vld_p0;
            if (vld_p0) rd_pixel <= oob_p0 ? BG_COLOR : (sel_p0 ? rdata1 : rdata0);
        end
    end
endmodule
